// File: rtl/led_panel_scan_ctrl_if.sv
// Pixel fetch bus between the scan sequencer (master) and the frame source (slave).
// Latency: none, wires only; the master holds a request until the slave answers with pix_valid.
// Backpressure: the slave stalls by withholding pix_valid; pix_valid without pix_req is ignored.
interface led_panel_scan_ctrl_if #(
  parameter int COL_W   = 5,
  parameter int PLANE_W = 1
);
  logic               pix_req;
  logic [COL_W-1:0]   pix_col;
  logic [2:0]         pix_row;
  logic [PLANE_W-1:0] pix_plane;
  logic               pix_valid;
  logic [2:0]         pix_rgb;

  modport master (
    output pix_req, pix_col, pix_row, pix_plane,
    input  pix_valid, pix_rgb
  );

  modport slave (
    input  pix_req, pix_col, pix_row, pix_plane,
    output pix_valid, pix_rgb
  );
endinterface

// File: rtl/led_panel_scan_ctrl.sv
// LED panel scan sequencer: fetches each row per bit plane, shifts it out, latches it and shows it with BCM.
// Latency: 2 cycles minimum per pixel; panel strobes and blank trail the state register by one cycle.
// Backpressure: pix_req holds column/row/plane stable until pix_valid; the scan waits indefinitely.
module led_panel_scan_ctrl #(
  parameter int COLS      = 32,
  parameter int PLANES    = 2,
  parameter int BASE_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           rowmax_in,
  led_panel_scan_ctrl_if.master pix,
  output logic                 red_out,
  output logic                 green_out,
  output logic                 blue_out,
  output logic                 sclk_out,
  output logic                 latch_out,
  output logic                 blank_out,
  output logic                 aclk_out,
  output logic                 arst_out,
  output logic                 frame_start
);
  localparam int COL_W    = $clog2(COLS);
  localparam int PLANE_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int HOLD_MAX = BASE_HOLD << (PLANES - 1);
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROWRST  = 3'd1,
    FETCH   = 3'd2,
    SCLK    = 3'd3,
    LATCH   = 3'd4,
    SHOW    = 3'd5,
    ADVANCE = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [2:0]         row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [2:0]         rowmax_q, rowmax_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [2:0]         rgb_q, rgb_d;
  logic               pix_req_q, pix_req_d;
  logic               sclk_q, sclk_d;
  logic               latch_q, latch_d;
  logic               blank_q, blank_d;
  logic               aclk_q, aclk_d;
  logic               arst_q, arst_d;
  logic               frame_q, frame_d;
  logic [31:0]        hold_last;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    plane_d   = plane_q;
    rowmax_d  = rowmax_q;
    hold_d    = hold_q;
    rgb_d     = rgb_q;
    hold_last = (32'(BASE_HOLD) << plane_q) - 32'd1;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ROWRST;
      end
      ROWRST: begin
        row_d    = 3'd0;
        col_d    = '0;
        plane_d  = '0;
        rowmax_d = rowmax_in;
        state_d  = FETCH;
      end
      FETCH: begin
        // pix_req is always high here, so a valid is a genuine handshake
        if (pix.pix_valid) begin
          rgb_d   = pix.pix_rgb;
          state_d = SCLK;
        end
      end
      SCLK: begin
        if (col_q == COL_W'(COLS - 1)) begin
          col_d   = '0;
          state_d = LATCH;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = FETCH;
        end
      end
      LATCH: begin
        hold_d  = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (32'(hold_q) == hold_last) begin
          hold_d = '0;
          if (32'(plane_q) < PLANES - 1) begin
            plane_d = plane_q + PLANE_W'(1);
            state_d = FETCH;
          end else begin
            plane_d = '0;
            if (!enable)                 state_d = IDLE;
            else if (row_q == rowmax_q)  state_d = ROWRST;
            else                         state_d = ADVANCE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ADVANCE: begin
        row_d   = row_q + 3'd1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // Request follows the next state so the handshake edge drops it at once.
    pix_req_d = (state_d == FETCH);
    // Strobes lag the state by a cycle: shifted data leads sclk by one cycle.
    sclk_d    = (state_q == SCLK);
    latch_d   = (state_q == LATCH);
    blank_d   = (state_q != SHOW);
    aclk_d    = (state_q == ADVANCE);
    arst_d    = (state_q == ROWRST);
    frame_d   = (state_q == ROWRST);
  end

  // State and output registers; reset darkens the panel immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= 3'd0;
      plane_q   <= '0;
      rowmax_q  <= 3'd0;
      hold_q    <= '0;
      rgb_q     <= 3'd0;
      pix_req_q <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      blank_q   <= 1'b1;
      aclk_q    <= 1'b0;
      arst_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      rowmax_q  <= rowmax_d;
      hold_q    <= hold_d;
      rgb_q     <= rgb_d;
      pix_req_q <= pix_req_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      blank_q   <= blank_d;
      aclk_q    <= aclk_d;
      arst_q    <= arst_d;
      frame_q   <= frame_d;
    end
  end

  assign pix.pix_req   = pix_req_q;
  assign pix.pix_col   = col_q;
  assign pix.pix_row   = row_q;
  assign pix.pix_plane = plane_q;

  assign red_out     = rgb_q[0];
  assign green_out   = rgb_q[1];
  assign blue_out    = rgb_q[2];
  assign sclk_out    = sclk_q;
  assign latch_out   = latch_q;
  assign blank_out   = blank_q;
  assign aclk_out    = aclk_q;
  assign arst_out    = arst_q;
  assign frame_start = frame_q;
endmodule
